// File: rtl/rv_prefetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_prefetch_unit_pkg
//  Brief    : Shared constants, types and helpers for the instruction prefetch unit.
//  Revision : 1.0 - initial release
// ============================================================================
package rv_prefetch_unit_pkg;

    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RSP_NONE   = 2'd0,
        RSP_PUSH   = 2'd1,
        RSP_DROP   = 2'd2,
        RSP_IGNORE = 2'd3
    } rsp_action_e;

    // Queue entry layout: {pc, fault, instruction word}
    function automatic int fetch_entry_width(input int xlen);
        return xlen + 33;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_prefetch_unit_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : rv_prefetch_unit_sync_fifo
//  Brief    : Registered synchronous FIFO with simultaneous push/pop, level and clear.
//  Revision : 1.0 - initial release
// ============================================================================
module rv_prefetch_unit_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic                         head_valid,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_LW-1:0]  r_level;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = pop && (r_level != '0);
    // A full queue still accepts a write when the head leaves in the same cycle.
    assign w_push = push && ((r_level != c_LW'(DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            r_level <= r_level + c_LW'(w_push) - c_LW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

    assign head_valid = (r_level != '0);
    assign head_data  = r_mem[r_rd_ptr];
    assign level      = r_level;

endmodule
`default_nettype wire

// File: rtl/rv_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : rv_prefetch_unit
//  Brief    : Credit-based instruction prefetch front end with redirect flush.
//  Revision : 1.0 - initial release
// ============================================================================
module rv_prefetch_unit #(
    parameter int              XLEN            = 32,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    output logic [XLEN-1:0]              imem_req_addr,
    input  logic                         imem_rsp_valid,
    input  logic [31:0]                  imem_rsp_data,
    input  logic                         imem_rsp_error,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_pc,
    output logic [31:0]                  out_instr,
    output logic                         out_fault,
    output logic [XLEN-1:0]              debug_fetch_pc,
    output logic [$clog2(DEPTH+1)-1:0]   debug_level
);

    import rv_prefetch_unit_pkg::*;

    localparam int              c_LW         = $clog2(DEPTH+1);
    localparam int              c_OW         = $clog2(MAX_OUTSTANDING+1);
    localparam int              c_CW         = $clog2(DEPTH+MAX_OUTSTANDING+1);
    localparam int              c_EW         = fetch_entry_width(XLEN);
    localparam logic [XLEN-1:0] c_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [c_OW-1:0] r_outstanding;
    logic [c_OW-1:0] r_discard;
    logic [c_OW-1:0] w_outstanding_next;
    logic [c_LW-1:0] w_level;
    logic [c_CW-1:0] w_credit_used;
    logic            w_accept;
    logic            w_rsp_taken;
    rsp_action_e     w_rsp_action;
    logic [c_EW-1:0] w_push_entry;
    logic [c_EW-1:0] w_head_entry;
    logic [XLEN-1:0] w_redirect_aligned;

    // Buffered entries plus in-flight requests must fit the queue: no overflow by construction.
    assign w_credit_used  = c_CW'(w_level) + c_CW'(r_outstanding);
    assign imem_req_valid = !reset && !redirect_valid
                            && (r_outstanding < c_OW'(MAX_OUTSTANDING))
                            && (w_credit_used < c_CW'(DEPTH));
    assign imem_req_addr  = r_fetch_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    always_comb begin
        w_rsp_action = RSP_NONE;
        if (imem_rsp_valid) begin
            if (r_outstanding == '0)                     w_rsp_action = RSP_IGNORE;
            else if (redirect_valid || r_discard != '0)  w_rsp_action = RSP_DROP;
            else                                         w_rsp_action = RSP_PUSH;
        end
    end

    assign w_rsp_taken        = (w_rsp_action == RSP_PUSH) || (w_rsp_action == RSP_DROP);
    assign w_outstanding_next = r_outstanding + c_OW'(w_accept) - c_OW'(w_rsp_taken);
    assign w_redirect_aligned = redirect_pc & c_ALIGN_MASK;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_outstanding_next;
            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_aligned;
                r_rsp_pc   <= w_redirect_aligned;
                // Every request still in flight after this cycle predates the redirect.
                r_discard  <= w_outstanding_next;
            end else begin
                if (w_accept)                   r_fetch_pc <= r_fetch_pc + XLEN'(4);
                if (w_rsp_action == RSP_PUSH)   r_rsp_pc   <= r_rsp_pc + XLEN'(4);
                if (w_rsp_action == RSP_DROP)   r_discard  <= r_discard - c_OW'(1);
            end
        end
    end

    assign w_push_entry = {r_rsp_pc, imem_rsp_error, imem_rsp_data};

    rv_prefetch_unit_sync_fifo #(
        .WIDTH (c_EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .clear      (redirect_valid),
        .push       (w_rsp_action == RSP_PUSH),
        .push_data  (w_push_entry),
        .pop        (out_ready),
        .head_valid (out_valid),
        .head_data  (w_head_entry),
        .level      (w_level)
    );

    assign out_pc         = w_head_entry[c_EW-1 -: XLEN];
    assign out_fault      = w_head_entry[32];
    assign out_instr      = out_fault ? c_NOP_INSTR : w_head_entry[31:0];
    assign debug_fetch_pc = r_fetch_pc;
    assign debug_level    = w_level;

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
        imem_rsp_valid |-> (r_outstanding != '0));

endmodule
`default_nettype wire

// File: tb/tb_rv_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv_prefetch_unit
//  Brief    : Scoreboard bench for rv_prefetch_unit with an in-order memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv_prefetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_error = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;
    logic [31:0] debug_fetch_pc;
    logic [2:0]  debug_level;

    always #5 clk = ~clk;

    rv_prefetch_unit #(
        .XLEN(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .imem_rsp_error(imem_rsp_error),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_fault(out_fault),
        .debug_fetch_pc(debug_fetch_pc), .debug_level(debug_level)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] tag;
        logic [31:0] due;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    mem_req_t    pend_q[$];
    exp_t        exp_q[$];
    logic [31:0] acc_log[$];
    int          errors = 0;
    int          checks = 0;
    int          pops = 0;
    logic [31:0] cyc = '0;
    logic [31:0] epoch = '0;
    logic [31:0] exp_fetch_pc = '0;
    logic [31:0] first_pop_pc = '0;
    logic        first_pop_armed = 1'b0;
    logic        seen_fault8 = 1'b0;
    logic        ovf = 1'b0;
    logic        g_req_ready = 1'b0;
    logic        g_out_ready = 1'b0;
    int          g_lat_min = 1;
    int          g_lat_max = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_1234;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return a == 32'h0000_0008;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: compares every consumed head against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!reset && debug_level > 3'd4) ovf = 1'b1;
        if (!reset && out_valid && out_ready) begin
            pops++;
            if (out_valid && out_fault && out_pc == 32'h8) seen_fault8 = 1'b1;
            if (first_pop_armed) begin
                first_pop_pc    = out_pc;
                first_pop_armed = 1'b0;
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got pc %h expected no output", out_pc);
            end else begin
                e = exp_q.pop_front();
                check("out_pc",    out_pc,             e.pc);
                check("out_instr", out_instr,          e.instr);
                check("out_fault", {31'b0, out_fault}, {31'b0, e.fault});
            end
        end
    end

    // One clock of stimulus: memory responses, redirect, handshakes and model update.
    task automatic step(input logic do_redir, input logic [31:0] rpc);
        mem_req_t    r;
        logic        rsp_v;
        logic [31:0] lat;
        @(negedge clk);
        cyc   = cyc + 1;
        rsp_v = 1'b0;
        r     = '{addr: '0, tag: '0, due: '0};
        if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            r     = pend_q.pop_front();
            rsp_v = 1'b1;
        end
        imem_rsp_valid = rsp_v;
        imem_rsp_data  = rsp_v ? mem_word(r.addr) : 32'h0;
        imem_rsp_error = rsp_v && mem_err(r.addr);
        redirect_valid = do_redir;
        redirect_pc    = rpc;
        imem_req_ready = g_req_ready;
        out_ready      = g_out_ready;
        #1;
        if (do_redir && imem_req_valid) begin
            checks++;
            errors++;
            $display("FAIL req_in_redirect: got valid 1 expected 0");
        end
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_fetch_pc);
            acc_log.push_back(exp_fetch_pc);
            lat = 32'($urandom_range(g_lat_max, g_lat_min));
            pend_q.push_back('{addr: exp_fetch_pc, tag: epoch, due: cyc + lat});
            exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
        #2;
        if (rsp_v && !do_redir && r.tag == epoch)
            exp_q.push_back('{pc: r.addr,
                              instr: mem_err(r.addr) ? 32'h0000_0013 : mem_word(r.addr),
                              fault: mem_err(r.addr)});
        if (do_redir) begin
            exp_q.delete();
            epoch           = epoch + 1;
            exp_fetch_pc    = rpc & 32'hFFFF_FFFC;
            first_pop_armed = 1'b1;
        end
    endtask

    initial begin
        int n;
        int p0;
        int burst;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("rst_out_valid", {31'b0, out_valid},      32'h0);
        check("rst_level",     32'(debug_level),        32'h0);
        check("rst_fetch_pc",  debug_fetch_pc,          32'h0);
        reset = 1'b0;

        // Streaming at one instruction per cycle; 0x8 returns an access fault.
        g_req_ready = 1'b1; g_out_ready = 1'b1; g_lat_min = 1; g_lat_max = 1;
        repeat (5) step(1'b0, '0);
        p0 = pops;
        repeat (20) step(1'b0, '0);
        check("stream_rate", 32'(pops - p0), 32'd20);
        check("first_addr0", acc_log[0], 32'h0);
        check("first_addr1", acc_log[1], 32'h4);
        check("first_addr2", acc_log[2], 32'h8);
        check("fault_at_8",  {31'b0, seen_fault8}, 32'h1);

        // Decode stall: credits limit issue to DEPTH requests.
        g_req_ready = 1'b0;
        repeat (6) step(1'b0, '0);
        g_req_ready = 1'b1; g_out_ready = 1'b0;
        step(1'b1, 32'h0000_0040);
        n = acc_log.size();
        repeat (10) step(1'b0, '0);
        check("stall_issued", 32'(acc_log.size() - n), 32'd4);
        check("stall_level",  32'(debug_level), 32'd4);
        check("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
        g_out_ready = 1'b1;
        repeat (8) step(1'b0, '0);

        // Redirect with two slow responses in flight.
        g_lat_min = 4; g_lat_max = 4;
        repeat (6) step(1'b0, '0);
        step(1'b1, 32'h0000_0100);
        repeat (15) step(1'b0, '0);
        check("redir_first_pc", first_pop_pc, 32'h0000_0100);

        // Address wrap at the top of the space.
        g_lat_min = 1; g_lat_max = 1;
        step(1'b1, 32'hFFFF_FFF8);
        n = acc_log.size();
        repeat (8) step(1'b0, '0);
        check("wrap_addr0", acc_log[n],   32'hFFFF_FFF8);
        check("wrap_addr1", acc_log[n+1], 32'hFFFF_FFFC);
        check("wrap_addr2", acc_log[n+2], 32'h0000_0000);
        check("wrap_first_pc", first_pop_pc, 32'hFFFF_FFF8);

        // Consecutive redirects under random latency and back-pressure.
        g_lat_min = 1; g_lat_max = 5;
        repeat (4) step(1'b0, '0);
        step(1'b1, 32'h0000_0203);
        step(1'b1, 32'h0000_0302);
        step(1'b1, 32'h0000_0401);
        burst = 0;
        for (int i = 0; i < 300; i++) begin
            g_out_ready = 1'($urandom_range(1, 0));
            g_req_ready = ($urandom_range(3, 0) != 0);
            if (burst > 0) begin
                burst--;
                step(1'b1, $urandom & 32'h0000_0FFF);
            end else begin
                if ($urandom_range(9, 0) == 0) burst = $urandom_range(3, 1);
                step(1'b0, '0);
            end
        end
        g_req_ready = 1'b0; g_out_ready = 1'b1;
        for (int i = 0; i < 200 && (pend_q.size() != 0 || exp_q.size() != 0); i++)
            step(1'b0, '0);
        check("drain_pending", 32'(pend_q.size()), 32'd0);
        check("drain_expected", 32'(exp_q.size()), 32'd0);
        check("no_overflow", {31'b0, ovf}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
